// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load units, the issue stage and the register file.
// The ALU, load and issue requesters drive the master side; the arbiter sits on the slave side.
interface regfile_wb_arbiter_if;
    logic        ALU_VALID;
    logic [2:0]  ALU_RD;
    logic [15:0] ALU_DATA;
    logic        ALU_READY;
    logic        MEM_VALID;
    logic [2:0]  MEM_RD;
    logic [15:0] MEM_DATA;
    logic        MEM_READY;
    logic        ISSUE_LE;
    logic [2:0]  ISSUE_RD;
    logic        RD_LE;
    logic [2:0]  RD;
    logic [15:0] DATA_IN;
    logic [7:0]  BUSY;

    modport master (
        output ALU_VALID, ALU_RD, ALU_DATA,
        output MEM_VALID, MEM_RD, MEM_DATA,
        output ISSUE_LE, ISSUE_RD,
        input  ALU_READY, MEM_READY,
        input  RD_LE, RD, DATA_IN, BUSY
    );

    modport slave (
        input  ALU_VALID, ALU_RD, ALU_DATA,
        input  MEM_VALID, MEM_RD, MEM_DATA,
        input  ISSUE_LE, ISSUE_RD,
        output ALU_READY, MEM_READY,
        output RD_LE, RD, DATA_IN, BUSY
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter with a registered register-file write port.
// Define SCOREBOARD_EN to build the per-register pending-write BUSY scoreboard.
module regfile_wb_arbiter (
    input  logic                 CLK,
    input  logic                 RST_N,
    regfile_wb_arbiter_if.slave  bus
);

    logic        r_last_mem;
    logic        r_rd_le;
    logic [2:0]  r_rd;
    logic [15:0] r_data;
    logic        w_alu_ready;
    logic        w_mem_ready;

    // Contention goes to whichever side did not win the previous transfer.
    always_comb begin
        w_alu_ready = RST_N & bus.ALU_VALID
                    & (~bus.MEM_VALID | r_last_mem);
        w_mem_ready = RST_N & bus.MEM_VALID
                    & (~bus.ALU_VALID | ~r_last_mem);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_mem <= 1'b1;
            r_rd_le    <= 1'b0;
            r_rd       <= 3'd0;
            r_data     <= 16'h0000;
        end else begin
            r_rd_le <= w_alu_ready | w_mem_ready;
            if (w_alu_ready) begin
                r_last_mem <= 1'b0;
                r_rd       <= bus.ALU_RD;
                r_data     <= bus.ALU_DATA;
            end else if (w_mem_ready) begin
                r_last_mem <= 1'b1;
                r_rd       <= bus.MEM_RD;
                r_data     <= bus.MEM_DATA;
            end
        end
    end

    assign bus.ALU_READY = w_alu_ready;
    assign bus.MEM_READY = w_mem_ready;
    assign bus.RD_LE     = r_rd_le;
    assign bus.RD        = r_rd;
    assign bus.DATA_IN   = r_data;

`ifdef SCOREBOARD_EN
    logic [7:0] r_busy;
    logic [7:0] w_set;
    logic [7:0] w_clr;

    always_comb begin
        w_set = bus.ISSUE_LE ? (8'd1 << bus.ISSUE_RD) : 8'd0;
        w_clr = r_rd_le ? (8'd1 << r_rd) : 8'd0;
    end

    // Set is applied after clear so a same-edge issue keeps the bit pending.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_busy <= 8'h00;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign bus.BUSY = r_busy;
`else
    logic w_unused_issue;

    assign w_unused_issue = ^{bus.ISSUE_LE, bus.ISSUE_RD};
    assign bus.BUSY       = 8'h00;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL expose these ports (name  direction  width  meaning):
 CLK  input  1  single clock; all state updates on rising edge.
 RST_N  input  1  asynchronous, active-low reset.
 ALU_VALID  input  1  ALU requests a register writeback.
 ALU_RD  input  3  ALU destination register.
 ALU_DATA  input  16  ALU writeback value.
 ALU_READY  output  1  ALU request granted this cycle; combinational.
 MEM_VALID  input  1  load unit requests a register writeback.
 MEM_RD  input  3  load destination register.
 MEM_DATA  input  16  load writeback value.
 MEM_READY  output  1  load request granted this cycle; combinational.
 ISSUE_LE  input  1  an instruction with destination ISSUE_RD issues.
 ISSUE_RD  input  3  destination of the issuing instruction.
 RD_LE  output  1  register-file write enable; registered.
 RD  output  3  register-file write address; registered.
 DATA_IN  output  16  register-file write data; registered.
 BUSY  output  8  per-register pending-write scoreboard; bit n = Rn.
REQ-002 SHALL have one clock, CLK, and an asynchronous active-low reset, RST_N; no other clock or reset.

Function
REQ-003 A transfer SHALL occur on a rising edge where xxx_VALID and xxx_READY are both 1.
REQ-004 At most one of ALU_READY and MEM_READY SHALL be 1 in any cycle.
REQ-005 xxx_READY SHALL be 0 whenever the corresponding xxx_VALID is 0.
REQ-006 When only one requester is valid, that requester SHALL get READY=1 in the same cycle.
REQ-007 When both are valid, the grant SHALL go to the requester not granted last; the one-bit LAST_GRANT state SHALL update only on a transfer.
REQ-008 A requester SHALL hold VALID, RD and DATA stable until it sees READY; the block does not check this.
REQ-009 A transfer at edge N SHALL drive RD_LE=1 and the granted RD/DATA onto RD/DATA_IN from edge N until edge N+1 (one-cycle latency, one-cycle pulse).
REQ-010 With no transfer at an edge, RD_LE SHALL be 0 and RD/DATA_IN SHALL hold their previous values.
REQ-011 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-012 With SCOREBOARD_EN defined, ISSUE_LE=1 at an edge SHALL set BUSY[ISSUE_RD] at that edge.
REQ-013 With SCOREBOARD_EN defined, an edge where RD_LE=1 SHALL clear BUSY[RD].
REQ-014 If the set in REQ-012 and the clear in REQ-013 target the same register at the same edge, the set SHALL win and the bit SHALL stay 1.
REQ-015 Issue to an already-busy register SHALL leave the bit at 1, with no count and no error flag.

Reset
REQ-016 While RST_N=0, these SHALL be forced immediately: RD_LE=0, RD=0, DATA_IN=16'h0000, BUSY=8'h00, LAST_GRANT=MEM (ALU wins the first contention).
REQ-017 While RST_N=0, ALU_READY and MEM_READY SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL drop any registered write not yet committed; no write SHALL appear after RST_N deasserts.

Configuration
REQ-019 Macro SCOREBOARD_EN defined: the BUSY scoreboard SHALL be built per REQ-012..015.
REQ-020 SCOREBOARD_EN undefined: BUSY SHALL be constant 8'h00, ISSUE_LE and ISSUE_RD SHALL be ignored, and no scoreboard flops SHALL be inferred.

Verification
REQ-021 ALU_VALID=1, ALU_RD=3, ALU_DATA=16'h1234, MEM_VALID=0 -> ALU_READY=1 same cycle; next cycle RD_LE=1, RD=3, DATA_IN=16'h1234; the cycle after, RD_LE=0.
REQ-022 After reset, both valid and held 4 cycles (ALU_RD=1/16'hAAAA, MEM_RD=2/16'h5555) -> grants ALU, MEM, ALU, MEM; RD sequence 1,2,1,2 with RD_LE=1 on 4 consecutive cycles.
REQ-023 SCOREBOARD_EN: ISSUE_LE=1, ISSUE_RD=5 -> BUSY=8'h20 next cycle; then MEM writes R5 -> BUSY=8'h00 on the edge after RD_LE=1.
REQ-024 SCOREBOARD_EN: BUSY[4]=1; ISSUE_RD=4 issues on the same edge RD_LE=1 with RD=4 -> BUSY[4] stays 1.
REQ-025 RST_N pulled low the cycle after a grant -> RD_LE=0 and DATA_IN=0 immediately; no write after release; the next contention goes to ALU.
REQ-026 SCOREBOARD_EN undefined: ISSUE_LE toggling with any ISSUE_RD -> BUSY stays 8'h00.
